// File: rtl/debug_unit_if.sv
// Byte-stream and pipeline debug bus between the host debug controller and
// the UART / pipeline side.
interface debug_unit_if #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_dunit_clk_en;
  logic               o_dunit_reset_pc;
  logic               o_dunit_w_mem;
  logic [NB_REG-1:0]  o_dunit_addr;
  logic [NB_REG-1:0]  o_dunit_data_if;
  logic [NB_REG-1:0]  i_dunit_reg;
  logic [NB_REG-1:0]  i_dunit_mem_data;
  logic               i_halt;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_done, i_dunit_reg, i_dunit_mem_data, i_halt,
    output o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data_if
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_done, i_dunit_reg, i_dunit_mem_data, i_halt,
    input  o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data_if
  );
endinterface

// File: rtl/debug_unit.sv
// Host debug controller: UART commands load instruction memory, reset the PC,
// run or single-step the core, and dump registers plus data memory back out.
module debug_unit #(
  parameter int NB_REG     = 32,
  parameter int NB_BYTE    = 8,
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 32,
  parameter int N_REGS     = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  debug_unit_if.master  bus
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_PC   = 8'h50;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] ACK      = 8'h06;
  localparam logic [NB_BYTE-1:0] NAK      = 8'h15;
  localparam logic [5:0]         REG_END  = 6'(N_REGS);
  localparam logic [5:0]         LAST_IDX = 6'(N_REGS + DMEM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_COUNT, S_LD_DATA, S_LD_WRITE, S_PC_RST, S_RUN, S_STEP,
    S_D_ADDR, S_D_LATCH, S_D_SEND, S_D_WAIT, S_TX_WAIT
  } state_t;

  state_t              state_q;
  logic [NB_BYTE-1:0]  tx_data_q;
  logic                tx_start_q;
  logic                step_en_q;
  logic                reset_pc_q;
  logic                w_mem_q;
  logic [NB_REG-1:0]   addr_q;
  logic [NB_REG-1:0]   data_if_q;
  logic [NB_REG-1:0]   rx_shift_q;
  logic [NB_REG-1:0]   tx_shift_q;
  logic [7:0]          n_words_q;
  logic [7:0]          word_cnt_q;
  logic [1:0]          byte_cnt_q;
  logic [5:0]          dump_idx_q;
  logic [NB_REG-1:0]   rx_word_d;
  logic [NB_REG-1:0]   dump_addr_d;

  // Registers map to their index, memory words to a byte address after them.
  always_comb begin
    rx_word_d = {rx_shift_q[NB_REG-NB_BYTE-1:0], bus.i_rx_data};
    if (dump_idx_q < REG_END) begin
      dump_addr_d = NB_REG'(dump_idx_q);
    end else begin
      dump_addr_d = NB_REG'({dump_idx_q - REG_END, 2'b00});
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      step_en_q  <= 1'b0;
      reset_pc_q <= 1'b0;
      w_mem_q    <= 1'b0;
      addr_q     <= '0;
      data_if_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      n_words_q  <= 8'd0;
      word_cnt_q <= 8'd0;
      byte_cnt_q <= 2'd0;
      dump_idx_q <= 6'd0;
    end else begin
      tx_start_q <= 1'b0;
      step_en_q  <= 1'b0;
      reset_pc_q <= 1'b0;
      w_mem_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_rx_valid) begin
            case (bus.i_rx_data)
              CMD_LOAD: state_q <= S_LD_COUNT;
              CMD_PC:   begin reset_pc_q <= 1'b1; state_q <= S_PC_RST; end
              CMD_RUN:  state_q <= S_RUN;
              CMD_STEP: begin step_en_q <= 1'b1; state_q <= S_STEP; end
              default:  state_q <= S_IDLE;
            endcase
          end
        end
        S_LD_COUNT: begin
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == 8'd0 || {1'b0, bus.i_rx_data} > 9'(IMEM_WORDS)) begin
              tx_data_q  <= NAK;
              tx_start_q <= 1'b1;
              state_q    <= S_TX_WAIT;
            end else begin
              n_words_q  <= bus.i_rx_data;
              word_cnt_q <= 8'd0;
              byte_cnt_q <= 2'd0;
              state_q    <= S_LD_DATA;
            end
          end
        end
        S_LD_DATA: begin
          if (bus.i_rx_valid) begin
            rx_shift_q <= rx_word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              data_if_q <= rx_word_d;
              addr_q    <= NB_REG'({word_cnt_q, 2'b00});
              w_mem_q   <= 1'b1;
              state_q   <= S_LD_WRITE;
            end
          end
        end
        S_LD_WRITE: begin
          word_cnt_q <= word_cnt_q + 8'd1;
          if (word_cnt_q == n_words_q - 8'd1) begin
            tx_data_q  <= ACK;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_WAIT;
          end else begin
            state_q <= S_LD_DATA;
          end
        end
        S_PC_RST: begin
          tx_data_q  <= ACK;
          tx_start_q <= 1'b1;
          state_q    <= S_TX_WAIT;
        end
        S_RUN: begin
          if (bus.i_halt) begin
            dump_idx_q <= 6'd0;
            state_q    <= S_D_ADDR;
          end
        end
        S_STEP: begin
          dump_idx_q <= 6'd0;
          state_q    <= S_D_ADDR;
        end
        S_D_ADDR: begin
          addr_q  <= dump_addr_d;
          state_q <= S_D_LATCH;
        end
        S_D_LATCH: begin
          tx_shift_q <= (dump_idx_q < REG_END) ? bus.i_dunit_reg : bus.i_dunit_mem_data;
          byte_cnt_q <= 2'd0;
          state_q    <= S_D_SEND;
        end
        S_D_SEND: begin
          tx_data_q  <= tx_shift_q[NB_REG-1 -: NB_BYTE];
          tx_shift_q <= {tx_shift_q[NB_REG-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
          tx_start_q <= 1'b1;
          state_q    <= S_D_WAIT;
        end
        S_D_WAIT: begin
          if (bus.i_tx_done) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q != 2'd3) begin
              state_q <= S_D_SEND;
            end else if (dump_idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
            end else begin
              dump_idx_q <= dump_idx_q + 6'd1;
              state_q    <= S_D_ADDR;
            end
          end
        end
        S_TX_WAIT: begin
          if (bus.i_tx_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Run enable is combinational so the core never advances past a halt.
  assign bus.o_dunit_clk_en   = ((state_q == S_RUN) && !bus.i_halt) || step_en_q;
  assign bus.o_tx_data        = tx_data_q;
  assign bus.o_tx_start       = tx_start_q;
  assign bus.o_dunit_reset_pc = reset_pc_q;
  assign bus.o_dunit_w_mem    = w_mem_q;
  assign bus.o_dunit_addr     = addr_q;
  assign bus.o_dunit_data_if  = data_if_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: UART command vectors against a simple
// register/memory model and a delayed transmitter.
module tb_debug_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_unit_if #(.NB_REG(32), .NB_BYTE(8)) bus ();

  debug_unit dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  // Pipeline model: reg i reads i, data word j reads 0xA0+j.
  assign bus.i_dunit_reg      = {27'd0, bus.o_dunit_addr[4:0]};
  assign bus.i_dunit_mem_data = 32'h0000_00A0 + {2'b00, bus.o_dunit_addr[31:2]};

  int n_checks = 0;
  int n_err    = 0;
  int tx_delay = 3;
  int hs_viol  = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] waddr_q[$];
  logic [31:0] wdata_q[$];
  int wmem_cyc = 0, clken_cyc = 0, halt_en_cyc = 0, rpc_cyc = 0;
  logic wmem_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.o_dunit_w_mem) begin
      wmem_cyc <= wmem_cyc + 1;
      if (!wmem_prev) begin
        waddr_q.push_back(bus.o_dunit_addr);
        wdata_q.push_back(bus.o_dunit_data_if);
      end
    end
    wmem_prev <= bus.o_dunit_w_mem;
    if (bus.o_dunit_clk_en) clken_cyc <= clken_cyc + 1;
    if (bus.o_dunit_clk_en && bus.i_halt) halt_en_cyc <= halt_en_cyc + 1;
    if (bus.o_dunit_reset_pc) rpc_cyc <= rpc_cyc + 1;
  end

  // Transmitter model: captures each started byte, answers tx_done after a delay.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        tx_q.push_back(bus.o_tx_data);
        for (int d = 0; d < tx_delay; d++) begin
          @(negedge clk);
          if (bus.o_tx_start) hs_viol++;
        end
        @(posedge clk); #1 bus.i_tx_done = 1'b1;
        @(posedge clk); #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (tx_q.size() < n) check("tx_timeout", tx_q.size(), n);
    repeat (tx_delay + 6) @(posedge clk);
  endtask

  task automatic check_dump(input string tag, input int b);
    check({tag, "_len"},  tx_q.size() - b, 256);
    check({tag, "_r0"},   {tx_q[b+0], tx_q[b+1], tx_q[b+2], tx_q[b+3]}, 32'h0000_0000);
    check({tag, "_r1"},   {tx_q[b+4], tx_q[b+5], tx_q[b+6], tx_q[b+7]}, 32'h0000_0001);
    check({tag, "_r31"},  {tx_q[b+124], tx_q[b+125], tx_q[b+126], tx_q[b+127]}, 32'h0000_001F);
    check({tag, "_m0"},   {tx_q[b+128], tx_q[b+129], tx_q[b+130], tx_q[b+131]}, 32'h0000_00A0);
    check({tag, "_m31"},  {tx_q[b+252], tx_q[b+253], tx_q[b+254], tx_q[b+255]}, 32'h0000_00BF);
    check({tag, "_hs"},   hs_viol, 0);
  endtask

  initial begin
    int b, c0, w0, r0, s, cnt;
    bus.i_rx_data = 8'h00; bus.i_rx_valid = 1'b0; bus.i_halt = 1'b0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rst_tx_data",  bus.o_tx_data, 0);
    check("rst_tx_start", bus.o_tx_start, 0);
    check("rst_clk_en",   bus.o_dunit_clk_en, 0);
    check("rst_reset_pc", bus.o_dunit_reset_pc, 0);
    check("rst_w_mem",    bus.o_dunit_w_mem, 0);
    check("rst_addr",     bus.o_dunit_addr, 0);
    check("rst_data_if",  bus.o_dunit_data_if, 0);
    check("rst_no_tx",    tx_q.size(), 0);

    // Load two words.
    b = tx_q.size(); c0 = clken_cyc;
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h3F);
    wait_tx(b + 1, 200);
    check("ld_wmem_cyc",  wmem_cyc, 2);
    check("ld_pulses",    waddr_q.size(), 2);
    check("ld_addr0",     waddr_q[0], 32'h0000_0000);
    check("ld_data0",     wdata_q[0], 32'h2001_0005);
    check("ld_addr1",     waddr_q[1], 32'h0000_0004);
    check("ld_data1",     wdata_q[1], 32'h0000_003F);
    check("ld_ack",       tx_q[b], 8'h06);
    check("ld_clk_en",    clken_cyc - c0, 0);

    // Bad word counts.
    b = tx_q.size(); w0 = wmem_cyc;
    send_byte(8'h4C); send_byte(8'h00);
    wait_tx(b + 1, 200);
    check("nak0", tx_q[b], 8'h15);
    send_byte(8'h4C); send_byte(8'h81);
    wait_tx(b + 2, 200);
    check("nak129", tx_q[b+1], 8'h15);
    check("nak_no_wmem", wmem_cyc - w0, 0);

    // Unknown command ignored, then PC reset.
    b = tx_q.size(); c0 = clken_cyc; r0 = rpc_cyc;
    send_byte(8'h7A);
    repeat (10) @(posedge clk);
    check("unk_no_tx", tx_q.size() - b, 0);
    send_byte(8'h50);
    wait_tx(b + 1, 200);
    check("pc_pulse", rpc_cyc - r0, 1);
    check("pc_ack",   tx_q[b], 8'h06);
    check("pc_len",   tx_q.size() - b, 1);
    check("pc_clk_en", clken_cyc - c0, 0);

    // Single step and dump.
    b = tx_q.size(); c0 = clken_cyc;
    send_byte(8'h53);
    wait_tx(b + 256, 256 * 20 + 200);
    check("step_clk_en", clken_cyc - c0, 1);
    check_dump("step", b);

    // Continuous run, halt after 10 enabled cycles.
    b = tx_q.size(); c0 = clken_cyc; s = halt_en_cyc;
    @(posedge clk); #1 bus.i_rx_data = 8'h43; bus.i_rx_valid = 1'b1;
    @(posedge clk); #1 bus.i_rx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.i_halt = 1'b1;
    wait_tx(b + 256, 256 * 20 + 200);
    check("run_clk_en", clken_cyc - c0, 10);
    check("run_halt_en", halt_en_cyc - s, 0);
    check_dump("run", b);

    // Already halted, slow transmitter.
    tx_delay = 50;
    b = tx_q.size(); c0 = clken_cyc;
    send_byte(8'h43);
    wait_tx(b + 256, 256 * 70 + 200);
    check("halted_clk_en", clken_cyc - c0, 0);
    check_dump("halted", b);

    // Reset in the middle of a dump.
    tx_delay = 3; bus.i_halt = 1'b0;
    b = tx_q.size();
    send_byte(8'h53);
    cnt = 0;
    while (tx_q.size() < b + 10 && cnt < 500) begin @(posedge clk); cnt++; end
    check("mid_reached", tx_q.size() >= b + 10, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("mid_rst_start", bus.o_tx_start, 0);
    check("mid_rst_addr",  bus.o_dunit_addr, 0);
    rst_n = 1'b1;
    s = tx_q.size();
    repeat (400) @(posedge clk);
    check("mid_no_more_tx", tx_q.size(), s);
    r0 = rpc_cyc;
    send_byte(8'h50);
    wait_tx(s + 1, 200);
    check("mid_idle_pc", rpc_cyc - r0, 1);
    check("mid_idle_ack", tx_q[s], 8'h06);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller that drives the pipeline's dunit_* interface from a UART byte stream.
- It loads programs into instruction memory, resets the PC, and runs the core either continuously or one step at a time.
- After every run or step it dumps the register file and data memory back to the host.
- It sits between the UART RX/TX byte interface and the pipeline top-level: it drives i_dunit_* and consumes o_dunit_reg, o_dunit_mem_data and o_halt.

Parameters:
- NB_REG, 32, data/address width of the dunit interface.
- NB_BYTE, 8, UART byte width.
- IMEM_WORDS, 128, instruction-memory capacity in words (512 bytes).
- DMEM_WORDS, 32, data-memory words dumped (128 bytes).
- N_REGS, 32, registers dumped.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle pulse to start transmission.
- i_tx_done  in  1  one-cycle pulse, transmitter idle again.
- o_dunit_clk_en  out  1  pipeline clock enable.
- o_dunit_reset_pc  out  1  PC reset pulse.
- o_dunit_w_mem  out  1  instruction-memory write strobe.
- o_dunit_addr  out  32  byte address for the instruction memory / register index / data-memory address.
- o_dunit_data_if  out  32  instruction word to write.
- i_dunit_reg  in  32  register-file read data (combinational from o_dunit_addr[4:0]).
- i_dunit_mem_data  in  32  data-memory read data (combinational from o_dunit_addr).
- i_halt  in  1  HALT instruction reached WB.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE. All outputs are 0: o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem, o_dunit_addr, o_dunit_data_if. Internal counters and shift registers are 0.
- Reset asserted mid-load, mid-run or mid-dump aborts the operation. No partial write completes after reset.
- Commands are accepted only in IDLE. Command is the i_rx_data value on an i_rx_valid pulse. Unknown bytes are ignored and the block stays in IDLE.
- 'L' (0x4C), load:
  - Go to LD_COUNT. The next byte is N.
  - If N=0 or N>IMEM_WORDS: send NAK 0x15, return to IDLE.
  - Otherwise receive 4*N bytes, MSB first, into a 32-bit shift register.
  - On each 4th byte, the following cycle (LD_WRITE) drives o_dunit_data_if=word, o_dunit_addr=4*k for k=0..N-1, and o_dunit_w_mem=1 for exactly 1 cycle.
  - After the write for k=N-1: send ACK 0x06, return to IDLE.
  - o_dunit_clk_en stays 0 throughout the load.
- 'P' (0x50), PC reset: o_dunit_reset_pc=1 for exactly 1 cycle, then send ACK 0x06, return to IDLE.
- 'C' (0x43), continuous run:
  - State RUN. o_dunit_clk_en = (state==RUN) & ~i_halt, combinational, so no cycle advances once i_halt is seen.
  - When i_halt=1 in RUN, go to DUMP.
  - If i_halt is already 1 on entry, zero cycles execute and the dump starts.
- 'S' (0x53), step: o_dunit_clk_en=1 for exactly 1 cycle (registered), then DUMP. Step executes even when i_halt=1.
- DUMP sequence (after C or S): for each of the N_REGS registers, then each of the DMEM_WORDS memory words:
  - D_ADDR: drive o_dunit_addr = register index i, or 4*j for memory.
  - D_LATCH: one cycle later, capture i_dunit_reg or i_dunit_mem_data into the TX shift register.
  - D_SEND: o_tx_data = byte (MSB first), o_tx_start pulse 1 cycle.
  - D_WAIT: wait for i_tx_done. Repeat for 4 bytes.
  - Total dump is 4*(N_REGS+DMEM_WORDS) = 256 bytes. Then return to IDLE.
- Every TX byte (ACK, NAK, dump) uses the same handshake: o_tx_start for exactly 1 cycle, and no new o_tx_start until i_tx_done has been seen.
- i_rx_valid pulses outside IDLE and outside the load states are dropped.
- o_dunit_clk_en is never 1 during LOAD, PC reset, DUMP or IDLE.
- Counters:
  - Word counter: 8 bits.
  - Byte counter: 2 bits, wraps 3->0.
  - Dump index: 6 bits. Registers use index 0..31, memory uses index 32..63 with address 4*(index-32).
- o_dunit_addr upper bits are zero-extended.

Test Plan:
- Reset released, no RX -> all outputs 0 and the block stays IDLE. Assert reset mid-dump -> o_tx_start is never pulsed again and the state is IDLE.
- RX 0x4C,0x02, then 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x3F -> w_mem pulses at addr 0 with data 0x20010005, then at addr 4 with data 0x0000003F, exactly 1 cycle each, then TX 0x06.
- RX 0x4C,0x00 -> TX 0x15, no w_mem pulse. Repeat with N=0x81 -> TX 0x15.
- RX 0x50 -> reset_pc high for exactly 1 cycle, then TX 0x06, clk_en stays 0.
- RX 0x53 with a register model where reg i = i and mem word j = 0xA0+j -> clk_en high for 1 cycle, then 256 TX bytes. Bytes 0..3 = 00 00 00 00, bytes 4..7 = 00 00 00 01, bytes 128..131 = 00 00 00 A0.
- RX 0x43 with i_halt raised after 10 cycles -> clk_en high for exactly 10 cycles and low in the cycle i_halt=1, then the 256-byte dump. RX 0x43 with i_halt already 1 -> zero enable cycles, then the dump. TX handshake holds while i_tx_done is delayed 50 cycles per byte.
